// File: rtl/time_counter_24h.sv
// 24-hour time-of-day counter with a 1 Hz prescaler and a
// two-button (mode/inc) set mode for hours and minutes.
module time_counter_24h #(
    parameter int CLK_DIV = 50000000,
    parameter int DIV_W   = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       inc,
    output logic [6:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic [1:0] setting,
    output logic       sec_tick
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  prescaler;
    logic              mode_q;
    logic              inc_q;
    logic              mode_rise;
    logic              inc_rise;
    logic              terminal;

    assign mode_rise = mode & ~mode_q;
    assign inc_rise  = inc & ~inc_q;
    assign terminal  = (prescaler == TERM);
    assign setting   = state;

    // State register for the RUN / SET_HOUR / SET_MIN mode machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Each mode press steps to the next state, wrapping back to RUN
    always_comb begin
        state_nx = state;
        if (mode_rise) begin
            unique case (state)
                RUN:      state_nx = SET_HOUR;
                SET_HOUR: state_nx = SET_MIN;
                SET_MIN:  state_nx = RUN;
                default:  state_nx = RUN;
            endcase
        end
    end

    // Button history, prescaler, tick pulse and time-of-day registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hours     <= 7'd0;
            minutes   <= 7'd0;
            seconds   <= 7'd0;
            prescaler <= '0;
            sec_tick  <= 1'b0;
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            mode_q   <= mode;
            inc_q    <= inc;
            sec_tick <= 1'b0;
            unique case (state)
                RUN: begin
                    // A mode press wins over a coinciding terminal count
                    if (!mode_rise) begin
                        if (terminal) begin
                            prescaler <= '0;
                            sec_tick  <= 1'b1;
                            if (seconds == 7'd59) begin
                                seconds <= 7'd0;
                                if (minutes == 7'd59) begin
                                    minutes <= 7'd0;
                                    if (hours == 7'd23) begin
                                        hours <= 7'd0;
                                    end else begin
                                        hours <= hours + 7'd1;
                                    end
                                end else begin
                                    minutes <= minutes + 7'd1;
                                end
                            end else begin
                                seconds <= seconds + 7'd1;
                            end
                        end else begin
                            prescaler <= prescaler + DIV_W'(1);
                        end
                    end
                end
                SET_HOUR: begin
                    if (inc_rise && !mode_rise) begin
                        if (hours == 7'd23) begin
                            hours <= 7'd0;
                        end else begin
                            hours <= hours + 7'd1;
                        end
                    end
                end
                SET_MIN: begin
                    // Leaving set mode restarts the second from zero
                    if (mode_rise) begin
                        seconds   <= 7'd0;
                        prescaler <= '0;
                    end else if (inc_rise) begin
                        if (minutes == 7'd59) begin
                            minutes <= 7'd0;
                        end else begin
                            minutes <= minutes + 7'd1;
                        end
                    end
                end
                default: begin
                    prescaler <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_counter_24h.sv
// Self-checking bench for time_counter_24h: directed scenarios plus
// random button/reset traffic against a seconds-of-day reference model.
module tb_time_counter_24h;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic       inc = 1'b0;
    logic [6:0] hours;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic [1:0] setting;
    logic       sec_tick;

    int checks = 0;
    int failures = 0;

    // reference model: time as seconds since midnight
    int tod = 0;
    int st = 0;
    int cnt = 0;
    bit pm = 0;
    bit pi = 0;
    bit mtick = 0;

    time_counter_24h #(.CLK_DIV(CD), .DIV_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .inc(inc),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .setting(setting),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit mr;
        bit ir;
        int h;
        int m;
        if (reset) begin
            tod = 0; st = 0; cnt = 0; pm = 0; pi = 0; mtick = 0;
        end else begin
            mr = mode && !pm;
            ir = inc && !pi;
            pm = mode;
            pi = inc;
            mtick = 0;
            if (st == 0) begin
                if (mr) st = 1;
                else begin
                    cnt++;
                    if (cnt == CD) begin
                        cnt = 0;
                        mtick = 1;
                        tod = (tod + 1) % 86400;
                    end
                end
            end else if (st == 1) begin
                if (mr) st = 2;
                else if (ir) begin
                    h = tod / 3600;
                    tod += ((h + 1) % 24 - h) * 3600;
                end
            end else begin
                if (mr) begin
                    st = 0;
                    cnt = 0;
                    tod -= tod % 60;
                end else if (ir) begin
                    m = (tod / 60) % 60;
                    tod += ((m + 1) % 60 - m) * 60;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("hours", int'(hours), tod / 3600);
        check("minutes", int'(minutes), (tod / 60) % 60);
        check("seconds", int'(seconds), tod % 60);
        check("setting", int'(setting), st);
        check("sec_tick", int'(sec_tick), int'(mtick));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press_mode();
        mode = 1'b1; cycle();
        mode = 1'b0; cycle();
    endtask

    task automatic press_inc();
        inc = 1'b1; cycle();
        inc = 1'b0; cycle();
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sec_tick && n < maxc);
        if (!sec_tick) check("tick_timeout", n, -1);
    endtask

    initial begin
        int n;
        int ticks;
        int exp_h[5];
        exp_h = '{22, 23, 0, 1, 2};

        // reset and first tick timing
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        check("rst_hours", int'(hours), 0);
        check("rst_minutes", int'(minutes), 0);
        check("rst_seconds", int'(seconds), 0);
        check("rst_setting", int'(setting), 0);
        wait_tick(10, n);
        check("first_tick_cycle", n, 4);
        check("first_tick_sec", int'(seconds), 1);
        wait_tick(10, n);
        check("tick_period", n, 4);

        // minute and hour carry
        ticks = 2;
        while (ticks < 60) begin wait_tick(10, n); ticks++; end
        check("carry_min_m", int'(minutes), 1);
        check("carry_min_s", int'(seconds), 0);
        while (ticks < 3600) begin wait_tick(10, n); ticks++; end
        check("carry_hr_h", int'(hours), 1);
        check("carry_hr_m", int'(minutes), 0);
        repeat (37) wait_tick(10, n);
        check("pre_set_sec", int'(seconds), 37);

        // set hours with wrap, seconds frozen
        press_mode();
        check("enter_set_hour", int'(setting), 1);
        repeat (20) press_inc();
        check("hour_21", int'(hours), 21);
        foreach (exp_h[k]) begin
            press_inc();
            check("set_hour_step", int'(hours), exp_h[k]);
        end
        check("set_hour_min", int'(minutes), 0);
        check("set_hour_sec", int'(seconds), 37);
        inc = 1'b1; run(10);
        inc = 1'b0; run(1);
        check("held_inc", int'(hours), 3);

        // exit through SET_MIN zeroes seconds and restarts prescaler
        press_mode();
        check("enter_set_min", int'(setting), 2);
        mode = 1'b1; cycle();
        check("exit_setting", int'(setting), 0);
        check("exit_seconds", int'(seconds), 0);
        mode = 1'b0;
        wait_tick(10, n);
        check("exit_tick_cycle", n, 4);

        // simultaneous mode+inc, then reset inside SET_MIN
        press_mode();
        mode = 1'b1; inc = 1'b1; cycle();
        check("simul_setting", int'(setting), 2);
        check("simul_hours", int'(hours), 3);
        mode = 1'b0; inc = 1'b0; cycle();
        press_inc();
        check("set_min_step", int'(minutes), 1);
        reset = 1'b1; cycle();
        check("midset_rst_setting", int'(setting), 0);
        check("midset_rst_h", int'(hours), 0);
        check("midset_rst_m", int'(minutes), 0);
        reset = 1'b0;

        // mode press coinciding with terminal count suppresses tick
        run(3);
        mode = 1'b1; cycle();
        check("term_mode_tick", int'(sec_tick), 0);
        check("term_mode_sec", int'(seconds), 0);
        check("term_mode_state", int'(setting), 1);
        mode = 1'b0; cycle();
        press_mode();
        press_mode();

        // random traffic
        repeat (4000) begin
            reset = ($urandom_range(0, 299) == 0);
            mode = ($urandom_range(0, 9) == 0);
            inc = ($urandom_range(0, 2) == 0);
            cycle();
        end
        reset = 1'b0; mode = 1'b0; inc = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
